systolic_feeder: RTL and testbench

Job controller and operand sequencer for the 3x3 8-bit systolic matrix-multiply array. It accepts a pair of 3x3 operand matrices through a valid/ready handshake and clears the array through the array's own reset pin. It then streams the A rows and B columns into the array's six edge inputs, waits for the wavefront to drain, and captures the 144-bit product into a result register with a valid/ready output handshake. It sits between the job source (host/DMA side) and the array; the array's internal skew buffers handle row/column staggering, so the feeder presents unskewed k-indexed data.

---
 rtl/systolic_feeder.sv | 150 +++++++++++++++
 tb/tb_systolic_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Job controller and operand sequencer for the 3x3 8-bit systolic array.
// Latches a job, clears the array, streams k-indexed operands, drains, and captures C.
module systolic_feeder #(
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start_valid,
    output logic           o_start_ready,
    input  logic [71:0]    i_mat_a,
    input  logic [71:0]    i_mat_b,
    output logic           o_arr_rst_n,
    output logic [7:0]     o_A11,
    output logic [7:0]     o_A21,
    output logic [7:0]     o_A31,
    output logic [7:0]     o_B11,
    output logic [7:0]     o_B12,
    output logic [7:0]     o_B13,
    input  logic [143:0]   i_arr_C,
    output logic           o_res_valid,
    input  logic           i_res_ready,
    output logic [143:0]   o_res_C
);

    localparam int unsigned N     = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 16;
    localparam int unsigned MAT_W = N * N * DW;
    localparam int unsigned RES_W = N * N * CW;
    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MAT_W-1:0]       mat_a_q, mat_a_d;
    logic [MAT_W-1:0]       mat_b_q, mat_b_d;
    logic                   arr_rst_n_q, arr_rst_n_d;
    logic                   start_ready_q, start_ready_d;
    logic [N-1:0][DW-1:0]   row_q, row_d;
    logic [N-1:0][DW-1:0]   col_q, col_d;
    logic                   res_valid_q, res_valid_d;
    logic [RES_W-1:0]       res_c_q, res_c_d;
    logic                   slot_free;
    logic [1:0]             feed_k;

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mat_a_d     = mat_a_q;
        mat_b_d     = mat_b_q;
        res_c_d     = res_c_q;
        res_valid_d = res_valid_q & ~i_res_ready;
        slot_free   = ~res_valid_q | i_res_ready;
        row_d       = '0;
        col_d       = '0;
        feed_k      = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (i_start_valid && start_ready_q) begin
                    state_d = S_CLEAR;
                    mat_a_d = i_mat_a;
                    mat_b_d = i_mat_b;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN, S_HOLD: begin
                if (state_q == S_DRAIN && cnt_q != CNT_W'(DRAIN_CYCLES - 1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (slot_free) begin
                    state_d     = S_IDLE;
                    res_c_d     = i_arr_C;
                    res_valid_d = 1'b1;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        arr_rst_n_d   = (state_d != S_CLEAR);
        start_ready_d = (state_d == S_IDLE);

        // Operands for the upcoming FEED cycle, unskewed: row r gets A[r][k], column c gets B[k][c].
        if (state_d == S_FEED) begin
            feed_k = cnt_d[1:0];
            for (int i = 0; i < N; i++) begin
                row_d[i] = mat_a_q[(i * N + int'(feed_k)) * DW +: DW];
                col_d[i] = mat_b_q[(int'(feed_k) * N + i) * DW +: DW];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mat_a_q       <= '0;
            mat_b_q       <= '0;
            arr_rst_n_q   <= 1'b0;
            start_ready_q <= 1'b1;
            row_q         <= '0;
            col_q         <= '0;
            res_valid_q   <= 1'b0;
            res_c_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mat_a_q       <= mat_a_d;
            mat_b_q       <= mat_b_d;
            arr_rst_n_q   <= arr_rst_n_d;
            start_ready_q <= start_ready_d;
            row_q         <= row_d;
            col_q         <= col_d;
            res_valid_q   <= res_valid_d;
            res_c_q       <= res_c_d;
        end
    end

    assign o_start_ready = start_ready_q;
    assign o_arr_rst_n   = arr_rst_n_q;
    assign o_A11         = row_q[0];
    assign o_A21         = row_q[1];
    assign o_A31         = row_q[2];
    assign o_B11         = col_q[0];
    assign o_B12         = col_q[1];
    assign o_B13         = col_q[2];
    assign o_res_valid   = res_valid_q;
    assign o_res_C       = res_c_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder with a behavioural accumulate-only array model.
module tb_systolic_feeder;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [71:0]    mat_a = '0;
    logic [71:0]    mat_b = '0;
    logic           arr_rst_n;
    logic [7:0]     a11, a21, a31, b11, b12, b13;
    logic [143:0]   arr_c;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [143:0]   res_c;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.DRAIN_CYCLES(5)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_mat_a       (mat_a),
        .i_mat_b       (mat_b),
        .o_arr_rst_n   (arr_rst_n),
        .o_A11         (a11),
        .o_A21         (a21),
        .o_A31         (a31),
        .o_B11         (b11),
        .o_B12         (b12),
        .o_B13         (b13),
        .i_arr_C       (arr_c),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_C       (res_c)
    );

    // Array stand-in: cleared by its reset pin, otherwise C[r][c] += row[r]*col[c] each edge.
    logic [7:0] arr_row [3];
    logic [7:0] arr_col [3];
    assign arr_row[0] = a11;
    assign arr_row[1] = a21;
    assign arr_row[2] = a31;
    assign arr_col[0] = b11;
    assign arr_col[1] = b12;
    assign arr_col[2] = b13;

    always_ff @(posedge clk) begin
        if (!arr_rst_n) begin
            arr_c <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    arr_c[(r*3+c)*16 +: 16] <= arr_c[(r*3+c)*16 +: 16]
                                              + 16'(arr_row[r]) * 16'(arr_col[c]);
                end
            end
        end
    end

    wire [47:0] ops = {a11, a21, a31, b11, b12, b13};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    function automatic logic [71:0] m8(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [143:0] c16(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        return {16'(e8), 16'(e7), 16'(e6), 16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    // Expected edge operands for step k: {A[0][k],A[1][k],A[2][k],B[k][0],B[k][1],B[k][2]}.
    function automatic logic [47:0] op_exp(input logic [71:0] a, input logic [71:0] b, input int k);
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            v[(5-i)*8 +: 8] = a[(i*3+k)*8 +: 8];
            v[(2-i)*8 +: 8] = b[(k*3+i)*8 +: 8];
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Full job with a free result slot: checks every cycle from handshake to capture, then consumes.
    task automatic run_job(input logic [71:0] a, input logic [71:0] b,
                           input logic [143:0] c, input string nm);
        chk1({nm, " ready_idle"}, start_ready, 1'b1);
        mat_a = a;
        mat_b = b;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        chk1({nm, " clear_arr_rst"}, arr_rst_n, 1'b0);
        chk({nm, " clear_ops"}, 144'(ops), 144'(0));
        chk1({nm, " busy_ready"}, start_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("%s feed_ops_k%0d", nm, k), 144'(ops), 144'(op_exp(a, b, k)));
            chk1($sformatf("%s feed_arr_rst_k%0d", nm, k), arr_rst_n, 1'b1);
        end
        for (int d = 0; d < 5; d++) begin
            step();
            chk($sformatf("%s drain_ops_%0d", nm, d), 144'(ops), 144'(0));
            chk1($sformatf("%s drain_valid_%0d", nm, d), res_valid, 1'b0);
        end
        step();
        chk1({nm, " valid_at_9"}, res_valid, 1'b1);
        chk({nm, " result"}, res_c, c);
        chk1({nm, " ready_after"}, start_ready, 1'b1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk1({nm, " consumed"}, res_valid, 1'b0);
    endtask

    typedef struct {
        logic [71:0]  a;
        logic [71:0]  b;
        logic [143:0] c;
    } vec_t;

    vec_t vecs [5];
    logic [71:0]  id_a, id_b, ones, twos;
    logic [143:0] id_c, six_c;
    int hs;

    initial begin
        id_a  = m8(1, 2, 3, 4, 5, 6, 7, 8, 9);
        id_b  = m8(1, 0, 0, 0, 1, 0, 0, 0, 1);
        id_c  = c16(1, 2, 3, 4, 5, 6, 7, 8, 9);
        ones  = m8(1, 1, 1, 1, 1, 1, 1, 1, 1);
        twos  = m8(2, 2, 2, 2, 2, 2, 2, 2, 2);
        six_c = c16(6, 6, 6, 6, 6, 6, 6, 6, 6);

        vecs[0] = '{id_a, id_b, id_c};
        vecs[1] = '{m8(255, 255, 255, 255, 255, 255, 255, 255, 255),
                    m8(255, 255, 255, 255, 255, 255, 255, 255, 255),
                    c16(64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003)};
        vecs[2] = '{ones, twos, six_c};
        vecs[3] = '{id_a, m8(9, 8, 7, 6, 5, 4, 3, 2, 1),
                    c16(30, 24, 18, 84, 69, 54, 138, 114, 90)};
        vecs[4] = '{m8(0, 0, 0, 0, 0, 0, 0, 0, 0), m8(7, 7, 7, 7, 7, 7, 7, 7, 7),
                    c16(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        // Reset state.
        step();
        step();
        chk1("rst arr_rst_n", arr_rst_n, 1'b0);
        chk("rst ops", 144'(ops), 144'(0));
        chk1("rst res_valid", res_valid, 1'b0);
        chk("rst res_c", res_c, 144'(0));
        chk1("rst start_ready", start_ready, 1'b1);
        rst_n = 1'b1;
        step();
        chk1("post_rst arr_rst_n", arr_rst_n, 1'b1);

        // Table jobs back to back, no external array reset in between.
        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].c, $sformatf("vec%0d", i));
        end

        // Second job stalls in HOLD behind an unconsumed result.
        mat_a = id_a;
        mat_b = id_b;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk1("stall job1 valid", res_valid, 1'b1);
        chk("stall job1 result", res_c, id_c);
        mat_a = ones;
        mat_b = twos;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("stall hold_c_%0d", i), res_c, id_c);
            chk1($sformatf("stall hold_valid_%0d", i), res_valid, 1'b1);
        end
        chk1("stall in_hold_ready", start_ready, 1'b0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk1("stall swap_valid", res_valid, 1'b1);
        chk("stall swap_result", res_c, six_c);
        chk1("stall swap_ready", start_ready, 1'b1);
        step();
        chk1("stall keep_valid", res_valid, 1'b1);
        chk("stall keep_result", res_c, six_c);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk1("stall consumed", res_valid, 1'b0);

        // Reset during FEED k=1 aborts the job.
        mat_a = id_a;
        mat_b = id_b;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        step();
        chk("midrst k1_ops", 144'(ops), 144'(op_exp(id_a, id_b, 1)));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst ops", 144'(ops), 144'(0));
        chk1("midrst arr_rst_n", arr_rst_n, 1'b0);
        chk1("midrst res_valid", res_valid, 1'b0);
        chk("midrst res_c", res_c, 144'(0));
        chk1("midrst start_ready", start_ready, 1'b1);
        step();
        chk1("midrst arr_rst_release", arr_rst_n, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk1($sformatf("midrst no_result_%0d", i), res_valid, 1'b0);
        end
        run_job(id_a, id_b, id_c, "after_rst");

        // start_valid held high: one job per IDLE visit, one per 10 cycles.
        mat_a = id_a;
        mat_b = id_b;
        res_ready = 1'b1;
        start_valid = 1'b1;
        hs = 0;
        for (int j = 0; j < 30; j++) begin
            if (start_ready) hs++;
            step();
        end
        start_valid = 1'b0;
        chk("held handshakes", 144'(hs), 144'(3));
        chk1("held last_valid", res_valid, 1'b1);
        chk("held last_result", res_c, id_c);
        chk1("held idle_ready", start_ready, 1'b1);
        step();
        res_ready = 1'b0;
        chk1("held consumed", res_valid, 1'b0);
        chk1("held no_extra_job", start_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
